// File: rtl/aes_key_expander_if.sv
// aes_key_expander_if: controller/key-expander bundle; AES_KEY_STORE_EN adds the round-key store read port
interface aes_key_expander_if #(parameter int KEY_W = 128);
  logic             start_expansion;
  logic [KEY_W-1:0] prev_key;
  logic [KEY_W-1:0] next_key;
  logic             key_valid;
  logic [3:0]       key_round;
  logic             finished_expansion;
  logic             busy;
`ifdef AES_KEY_STORE_EN
  logic [3:0]       rk_rd_idx;
  logic [KEY_W-1:0] rk_rd_data;
  modport master (output start_expansion, prev_key, rk_rd_idx,
                  input next_key, key_valid, key_round, finished_expansion, busy, rk_rd_data);
  modport slave (input start_expansion, prev_key, rk_rd_idx,
                 output next_key, key_valid, key_round, finished_expansion, busy, rk_rd_data);
`else
  modport master (output start_expansion, prev_key,
                  input next_key, key_valid, key_round, finished_expansion, busy);
  modport slave (input start_expansion, prev_key,
                 output next_key, key_valid, key_round, finished_expansion, busy);
`endif
endinterface

// File: rtl/aes_key_expander.sv
// aes_key_expander: AES-128 key schedule, round keys 1..10 one per clock; AES_KEY_STORE_EN adds an 11-entry round-key store
module aes_key_expander #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_W      = 128
) (
  input logic clk,
  input logic reset,
  aes_key_expander_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXPAND} state_t;
  state_t           st;
  logic [KEY_W-1:0] key_q;
  logic [3:0]       round_q;
  logic             valid_q;
  logic             fin_q;
  logic             busy_q;
  logic [7:0]       rcon;
  logic [7:0]       rcon_nx;
  logic [KEY_W-1:0] src;
  logic [KEY_W-1:0] rk;
  logic [31:0]      t;
  logic             last;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] e;
    r = 8'h01;
    e = 8'd254;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      r = e[i] ? gmul(r, a) : r;
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  assign last    = round_q == 4'(NUM_ROUNDS);
  assign rcon_nx = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
  assign src     = st == IDLE ? bus.prev_key : key_q;
  assign t       = {sbox(src[23:16]), sbox(src[15:8]), sbox(src[7:0]), sbox(src[31:24])} ^ {rcon, 24'h0};
  assign rk[127:96] = src[127:96] ^ t;
  assign rk[95:64]  = src[95:64] ^ rk[127:96];
  assign rk[63:32]  = src[63:32] ^ rk[95:64];
  assign rk[31:0]   = src[31:0] ^ rk[63:32];

  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= IDLE;
      key_q   <= '0;
      round_q <= 4'd0;
      valid_q <= 1'b0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
      rcon    <= 8'h01;
    end else begin
      case (st)
        IDLE: if (bus.start_expansion) begin
          st      <= EXPAND;
          key_q   <= rk;
          round_q <= 4'd1;
          valid_q <= 1'b1;
          busy_q  <= 1'b1;
          rcon    <= rcon_nx;
        end
        EXPAND: if (last) begin
          st      <= IDLE;
          round_q <= 4'd0;
          valid_q <= 1'b0;
          fin_q   <= 1'b0;
          busy_q  <= 1'b0;
          rcon    <= 8'h01;
        end else begin
          key_q   <= rk;
          round_q <= round_q + 4'd1;
          fin_q   <= round_q == 4'(NUM_ROUNDS - 1);
          rcon    <= rcon_nx;
        end
        default: begin
          st      <= IDLE;
          round_q <= 4'd0;
          valid_q <= 1'b0;
          fin_q   <= 1'b0;
          busy_q  <= 1'b0;
          rcon    <= 8'h01;
        end
      endcase
    end
  end

  assign bus.next_key           = key_q;
  assign bus.key_valid          = valid_q;
  assign bus.key_round          = round_q;
  assign bus.finished_expansion = fin_q;
  assign bus.busy               = busy_q;

`ifdef AES_KEY_STORE_EN
  logic [KEY_W-1:0] store [0:NUM_ROUNDS];
  logic [KEY_W-1:0] rd_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) store[i] <= '0;
      rd_q <= '0;
    end else begin
      if (st == IDLE && bus.start_expansion) begin
        store[0] <= bus.prev_key;
        store[1] <= rk;
      end
      if (st == EXPAND && !last) store[round_q + 4'd1] <= rk;
      rd_q <= bus.rk_rd_idx <= 4'(NUM_ROUNDS) ? store[bus.rk_rd_idx] : '0;
    end
  end
  assign bus.rk_rd_data = rd_q;
`endif
endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: directed FIPS-197 / zero-key checks of the AES-128 key expander
module tb_aes_key_expander;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [127:0] fk [0:10];
  logic [127:0] zk1 = 128'h62636363_62636363_62636363_62636363;
  logic [127:0] zk10 = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;
  logic [127:0] junk = 128'hdeadbeef_01234567_89abcdef_cafef00d;

  aes_key_expander_if #(.KEY_W(128)) bus();
  aes_key_expander dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [134:0] obs();
    return {bus.next_key, bus.key_round, bus.key_valid, bus.busy, bus.finished_expansion};
  endfunction

  task automatic test_reset();
    logic [134:0] e;
    reset = 1'b1;
    bus.start_expansion = 1'b1;
    bus.prev_key = fk[0];
    repeat (2) @(negedge clk);
    e = '0;
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_state: got %h want %h", obs(), e); end
    reset = 1'b0;
    bus.start_expansion = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL idle_after_reset: got %h want %h", obs(), e); end
  endtask

  task automatic test_fips();
    logic [134:0] e;
    bus.start_expansion = 1'b1;
    bus.prev_key = fk[0];
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.start_expansion = 1'b0;
      bus.prev_key = junk;
      e = {fk[k], 4'(k), 1'b1, 1'b1, k == 10};
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL fips_rk%0d: got %h want %h", k, obs(), e); end
    end
    @(negedge clk);
    e = {fk[10], 4'd0, 3'b000};
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL fips_idle: got %h want %h", obs(), e); end
  endtask

`ifdef AES_KEY_STORE_EN
  task automatic test_key_store();
    logic [3:0] idx [0:4];
    logic [127:0] e [0:4];
    idx = '{4'd0, 4'd10, 4'd12, 4'd5, 4'd15};
    e = '{fk[0], fk[10], 128'h0, fk[5], 128'h0};
    for (int i = 0; i < 5; i++) begin
      bus.rk_rd_idx = idx[i];
      @(negedge clk);
      checks++;
      if (bus.rk_rd_data !== e[i]) begin
        errors++;
        $display("FAIL store_idx%0d: got %h want %h", idx[i], bus.rk_rd_data, e[i]);
      end
    end
  endtask
`endif

  task automatic test_zero_key();
    logic [134:0] e;
    bus.start_expansion = 1'b1;
    bus.prev_key = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.start_expansion = 1'b0;
      if (k == 1 || k == 10) begin
        e = {k == 1 ? zk1 : zk10, 4'(k), 1'b1, 1'b1, k == 10};
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL zero_rk%0d: got %h want %h", k, obs(), e); end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    logic [134:0] e;
    bus.start_expansion = 1'b1;
    bus.prev_key = fk[0];
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      e = {fk[k], 4'(k), 1'b1, 1'b1, k == 10};
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL ignore_rk%0d: got %h want %h", k, obs(), e); end
      bus.start_expansion = k == 4;
      bus.prev_key = k == 4 ? '0 : fk[0];
    end
    @(negedge clk);
    e = {fk[10], 4'd0, 3'b000};
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL ignore_idle: got %h want %h", obs(), e); end
  endtask

  task automatic test_reset_mid();
    logic [134:0] e;
    bus.start_expansion = 1'b1;
    bus.prev_key = fk[0];
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus.start_expansion = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    e = '0;
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL midreset_state: got %h want %h", obs(), e); end
    reset = 1'b0;
    @(negedge clk);
    bus.start_expansion = 1'b1;
    bus.prev_key = '0;
    @(negedge clk);
    bus.start_expansion = 1'b0;
    e = {zk1, 4'd1, 3'b110};
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL midreset_rk1: got %h want %h", obs(), e); end
    repeat (10) @(negedge clk);
    e = {zk10, 4'd0, 3'b000};
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL midreset_idle: got %h want %h", obs(), e); end
  endtask

  task automatic test_back_to_back();
    logic [134:0] e;
    logic [3:0] r;
    int accepts;
    int fins;
    int n;
    accepts = 0;
    fins = 0;
    bus.start_expansion = 1'b1;
    bus.prev_key = fk[0];
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      r = i < 10 ? 4'(i + 1) : (i == 10 || i == 21) ? 4'd0 : 4'(i - 10);
      e = {fk[r == 4'd0 ? 10 : int'(r)], r, r != 4'd0, r != 4'd0, i == 9 || i == 20};
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL b2b_cycle%0d: got %h want %h", i, obs(), e); end
      accepts += bus.key_round == 4'd1 ? 1 : 0;
      fins += bus.finished_expansion ? 1 : 0;
    end
    checks++;
    if (accepts !== 2) begin errors++; $display("FAIL b2b_accepts: got %0d want 2", accepts); end
    checks++;
    if (fins !== 2) begin errors++; $display("FAIL b2b_finishes: got %0d want 2", fins); end
    repeat (3) @(negedge clk);
    bus.start_expansion = 1'b0;
    n = 0;
    while (bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    e = {fk[10], 4'd0, 3'b000};
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL b2b_drain: got %h want %h after %0d cycles", obs(), e, n); end
  endtask

  initial begin
    fk[0]  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    fk[1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    fk[2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
    fk[3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
    fk[4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
    fk[5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
    fk[6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
    fk[7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
    fk[8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
    fk[9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
    fk[10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    bus.start_expansion = 1'b0;
    bus.prev_key = '0;
`ifdef AES_KEY_STORE_EN
    bus.rk_rd_idx = 4'd0;
`endif
    test_reset();
    test_fips();
`ifdef AES_KEY_STORE_EN
    test_key_store();
`endif
    test_zero_key();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- AES-128 key schedule stage; sits beside the encryption controller.
- Accepts the cipher key on a one-cycle start pulse and produces round keys 1..10, one per clock.
- The controller XORs each round key with the round state.
- Signals the controller when round key 10 is presented, so it can latch the ciphertext.

Parameters:
- NUM_ROUNDS, 10, number of round keys generated after the cipher key (fixed at 10 for AES-128; other values unsupported).
- KEY_W, 128, key width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start_expansion  input  1  one-cycle request; samples prev_key.
- prev_key  input  KEY_W  cipher key (round key 0); valid when start_expansion=1.
- next_key  output  KEY_W  current round key, registered.
- key_valid  output  1  next_key holds a new round key this cycle.
- key_round  output  4  index of round key on next_key (1..10; 0 when idle).
- finished_expansion  output  1  one-cycle pulse coincident with round key 10.
- busy  output  1  expansion in progress.

Behaviour:
- Reset (synchronous, clk edge with reset=1): all outputs 0, state IDLE, rcon register 8'h01, internal key register 0. Reset dominates start_expansion and any in-flight expansion.
- States:
  - IDLE --start_expansion--> EXPAND.
  - EXPAND stays until key_round==NUM_ROUNDS, then returns to IDLE on the next edge.
  - Illegal state -> IDLE.
- Round function, for key register w0..w3 (w0 = bits [127:96]):
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'
  - RotWord = left rotate by one byte. SubWord = AES S-box on each byte; four combinational S-box instances inside the block.
- rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
  - Next rcon = xtime(rcon): shift left 1, XOR 8'h1B if bit7 was set.
  - Reloads to 01 when returning to IDLE.
- Latency, with start_expansion=1 sampled in IDLE at edge T:
  - Edge T: next_key <= RK1, key_round <= 1, key_valid <= 1, busy <= 1.
  - Edge T+k (k=1..9): next_key <= RK(k+1), key_round <= k+1.
  - During the cycle after edge T+9: key_round=10, finished_expansion=1 (single cycle), next_key=RK10.
  - Edge T+10: state IDLE, key_valid=0, busy=0, key_round=0, finished_expansion=0. next_key holds RK10 until the next start or reset.
- Round keys are available one cycle after start, back to back, with no bubbles.
- start_expansion while busy=1: ignored; prev_key not sampled; sequence continues unaltered.
- start_expansion in the cycle finished_expansion=1: ignored (block still busy). A new start is accepted from the following cycle, giving a minimum 11-cycle start-to-start spacing.
- prev_key is sampled only at the accepted start edge; later changes have no effect.
- All outputs are registered. No combinational path from inputs to outputs.

Optional Feature:
- Macro: AES_KEY_STORE_EN.
- Defined:
  - Adds an 11-entry x KEY_W round-key store, with ports rk_rd_idx (input, 4) and rk_rd_data (output, KEY_W).
  - Entry 0 is written with prev_key at the accepted start; entry k is written with RKk at the same edge that drives it onto next_key.
  - rk_rd_data is registered: one-cycle read latency.
  - rk_rd_idx > 10 returns 0.
  - Store clears to 0 on reset.
  - Intended for a future decryption path.
- Undefined: the ports and store are absent; all other behaviour is identical.

Test Plan:
- FIPS-197 key 2b7e1516_28aed2a6_abf71588_09cf4f3c, start pulse -> one cycle later next_key=a0fafe17_88542cb1_23a33939_2a6c7605 with key_round=1 and key_valid=1; 10 cycles after start, next_key=d014f9a8_c9ee2589_e13f0cc8_b6630ca6, key_round=10, finished_expansion=1 for exactly one cycle.
- All-zero key -> RK1=62636363_62636363_62636363_62636363; RK10=b4ef5bcb_3e92e211_23e951cf_6f8f188e.
- Second start pulse at key_round=4, with a different prev_key -> ignored; the full RK5..RK10 sequence of the first key completes unchanged.
- reset=1 at key_round=6 -> next edge: all outputs 0, busy=0; a start two cycles later produces the correct RK1 for the new key.
- start held high for 25 cycles -> exactly two back-to-back expansions. Starts are accepted at cycles 0 and 11; finished_expansion pulses at cycles 10 and 21; no other accept.
- AES_KEY_STORE_EN defined, after FIPS-197 expansion: rk_rd_idx=0 -> rk_rd_data=2b7e1516_28aed2a6_abf71588_09cf4f3c next cycle; rk_rd_idx=10 -> RK10; rk_rd_idx=12 -> 0.
